stream_accumulator: RTL and testbench

- Parametrised successor to the team's combinational 8-bit adder.
- Sums a packet of up to N_TERMS operands arriving serially on a valid/ready stream.
- Produces three results per packet: the full-precision sum, a WIDTH-bit saturated result and an overflow flag.
- Forms the neuron's weighted-sum accumulation stage, sitting between the multiply stage and the activation stage.

---
 rtl/stream_accumulator_if.sv | 24 ++
 rtl/stream_accumulator.sv | 68 ++++++
 tb/tb_stream_accumulator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_accumulator_if.sv
// stream_accumulator_if: valid/ready operand and result streams of the stream accumulator
// in_valid/in_ready/in_data/in_last         : operand stream, master to slave
// out_valid/out_ready/out_sum/out_sat/out_ovf/out_count : result stream, slave to master
interface stream_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int N_TERMS = 4
);
  localparam int SUM_W = WIDTH + $clog2(N_TERMS);
  localparam int CNT_W = $clog2(N_TERMS + 1);
  logic in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_data;
  logic out_valid, out_ready, out_ovf;
  logic [SUM_W-1:0] out_sum;
  logic [WIDTH-1:0] out_sat;
  logic [CNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_sum, out_sat, out_ovf, out_count
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_ovf, out_count
  );
endinterface

// File: rtl/stream_accumulator.sv
// stream_accumulator: sums packets of up to N_TERMS serial operands into full, saturated and overflow results
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// s     : slave side of stream_accumulator_if (operand stream in, result stream out)
module stream_accumulator #(
  parameter int WIDTH = 8,
  parameter int N_TERMS = 4,
  parameter int SIGNED = 0,
  parameter int SUM_W = WIDTH + $clog2(N_TERMS),
  parameter int CNT_W = $clog2(N_TERMS + 1)
) (
  input logic clk,
  input logic rst_n,
  stream_accumulator_if.slave s
);
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SMIN = ~SMAX;
  typedef enum logic {ACC, HOLD} state_t;
  state_t state;
  logic signed [WIDTH-1:0] din_s;
  logic [SUM_W-1:0] acc, ext, sum;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] sat;
  logic xfer, term, hi, lo;
  assign din_s = s.in_data;
  assign ext = SIGNED != 0 ? SUM_W'(din_s) : SUM_W'(s.in_data);
  // acc is zero at the start of every packet, so the first beat needs no special case
  assign sum = acc + ext;
  assign cnt_nx = cnt + 1'b1;
  assign xfer = s.in_valid && s.in_ready;
  assign term = xfer && (s.in_last || cnt == CNT_W'(N_TERMS - 1));
  assign hi = SIGNED != 0 ? $signed(sum) > SMAX : (sum >> WIDTH) != '0;
  assign lo = SIGNED != 0 && $signed(sum) < SMIN;
  assign sat = hi ? (SIGNED != 0 ? SMAX[WIDTH-1:0] : '1) : lo ? SMIN[WIDTH-1:0] : sum[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      s.in_ready <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_sum <= '0;
      s.out_sat <= '0;
      s.out_ovf <= 1'b0;
      s.out_count <= '0;
    end else if (state == ACC) begin
      s.in_ready <= !term;
      if (xfer) begin
        acc <= sum;
        cnt <= cnt_nx;
      end
      if (term) begin
        state <= HOLD;
        s.out_valid <= 1'b1;
        s.out_sum <= sum;
        s.out_sat <= sat;
        s.out_ovf <= hi || lo;
        s.out_count <= cnt_nx;
      end
    end else if (s.out_ready) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      s.in_ready <= 1'b1;
      s.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator: scoreboard bench driving an unsigned and a signed accumulator with identical streams
module tb_stream_accumulator;
  typedef struct {
    logic [9:0] us, ss;
    logic [7:0] usat, ssat;
    logic uovf, sovf;
    logic [2:0] cnt;
  } exp_t;
  logic clk = 0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [7:0] in_data;
  bit rand_ready;
  int errs = 0;
  int checks = 0;
  logic [7:0] cur[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  stream_accumulator_if #(.WIDTH(8), .N_TERMS(4)) ua ();
  stream_accumulator_if #(.WIDTH(8), .N_TERMS(4)) va ();
  assign ua.in_valid = in_valid;
  assign ua.in_data = in_data;
  assign ua.in_last = in_last;
  assign ua.out_ready = out_ready;
  assign va.in_valid = in_valid;
  assign va.in_data = in_data;
  assign va.in_last = in_last;
  assign va.out_ready = out_ready;
  stream_accumulator #(.WIDTH(8), .N_TERMS(4), .SIGNED(0)) u_dut (.clk(clk), .rst_n(rst_n), .s(ua.slave));
  stream_accumulator #(.WIDTH(8), .N_TERMS(4), .SIGNED(1)) v_dut (.clk(clk), .rst_n(rst_n), .s(va.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model();
    exp_t e;
    int us = 0;
    int ss = 0;
    byte sb8;
    foreach (cur[i]) begin
      us += int'(cur[i]);
      sb8 = cur[i];
      ss += int'(sb8);
    end
    e.us = 10'(us);
    e.uovf = us > 255;
    e.usat = us > 255 ? 8'hFF : 8'(us);
    e.ss = 10'(ss);
    e.sovf = ss > 127 || ss < -128;
    e.ssat = ss > 127 ? 8'h7F : ss < -128 ? 8'h80 : 8'(ss);
    e.cnt = 3'(cur.size());
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ua.out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result: got sum %0h expected no result at %0t", ua.out_sum, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_v_valid", va.out_valid, 1);
        chk("sb_u_sum", ua.out_sum, e.us);
        chk("sb_u_sat", ua.out_sat, e.usat);
        chk("sb_u_ovf", ua.out_ovf, e.uovf);
        chk("sb_u_count", ua.out_count, e.cnt);
        chk("sb_s_sum", va.out_sum, e.ss);
        chk("sb_s_sat", va.out_sat, e.ssat);
        chk("sb_s_ovf", va.out_ovf, e.sovf);
        chk("sb_s_count", va.out_count, e.cnt);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end
  task automatic beat(input logic [7:0] d, input bit l);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (!ua.in_ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ua.in_ready) chk("in_ready_timeout", ua.in_ready, 1);
    else begin
      @(posedge clk);
      #1;
      cur.push_back(d);
      if (l || cur.size() == 4) begin
        sb.push_back(model());
        cur.delete();
      end
    end
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic pkt(input int n, input logic [7:0] d0, d1, d2, d3, input bit lst);
    logic [7:0] d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < n; i++) beat(d[i], lst && i == n - 1);
  endtask
  task automatic release_out();
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask
  initial begin
    int n;
    rst_n = 0;
    in_valid = 0;
    in_last = 0;
    in_data = 0;
    out_ready = 0;
    rand_ready = 0;
    #2;
    chk("rst_in_ready", ua.in_ready, 0);
    chk("rst_out_valid", ua.out_valid, 0);
    chk("rst_out_sum", ua.out_sum, 0);
    chk("rst_out_count", ua.out_count, 0);
    #10 rst_n = 1;
    #1 chk("in_ready_before_edge", ua.in_ready, 0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", ua.in_ready, 1);
    pkt(3, 5, 10, 100, 0, 0);
    chk("latency_not_early", ua.out_valid, 0);
    beat(200, 0);
    chk("p1_valid", ua.out_valid, 1);
    chk("p1_sum", ua.out_sum, 315);
    chk("p1_sat", ua.out_sat, 255);
    chk("p1_ovf", ua.out_ovf, 1);
    chk("p1_count", ua.out_count, 4);
    chk("p1_in_ready", ua.in_ready, 0);
    in_valid = 1;
    in_data = 9;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", ua.in_ready, 0);
      chk("bp_valid", ua.out_valid, 1);
      chk("bp_sum", ua.out_sum, 315);
      chk("bp_count", ua.out_count, 4);
    end
    in_valid = 0;
    release_out();
    chk("bp_in_ready_back", ua.in_ready, 1);
    chk("bp_valid_drop", ua.out_valid, 0);
    chk("bp_sum_retained", ua.out_sum, 315);
    pkt(4, 1, 2, 3, 4, 0);
    chk("p2_sum", ua.out_sum, 10);
    release_out();
    pkt(4, 0, 0, 0, 0, 0);
    chk("zero_sum", ua.out_sum, 0);
    chk("zero_ovf", ua.out_ovf, 0);
    chk("zero_count", ua.out_count, 4);
    release_out();
    pkt(2, 255, 1, 0, 0, 1);
    chk("early_sum", ua.out_sum, 256);
    chk("early_sat", ua.out_sat, 255);
    chk("early_ovf", ua.out_ovf, 1);
    chk("early_count", ua.out_count, 2);
    release_out();
    pkt(1, 127, 0, 0, 0, 1);
    chk("single_sum", ua.out_sum, 127);
    chk("single_ovf", ua.out_ovf, 0);
    chk("single_count", ua.out_count, 1);
    release_out();
    pkt(4, 8'h80, 8'h80, 8'h80, 8'h80, 1);
    chk("s_neg_sum", va.out_sum, 10'h200);
    chk("s_neg_sat", va.out_sat, 8'h80);
    chk("s_neg_ovf", va.out_ovf, 1);
    chk("last_on_max_count", ua.out_count, 4);
    release_out();
    pkt(2, 127, 1, 0, 0, 1);
    chk("s_pos_sum", va.out_sum, 10'h080);
    chk("s_pos_sat", va.out_sat, 8'h7F);
    chk("s_pos_ovf", va.out_ovf, 1);
    release_out();
    pkt(2, 8'hFB, 3, 0, 0, 1);
    chk("s_small_sum", va.out_sum, 10'h3FE);
    chk("s_small_ovf", va.out_ovf, 0);
    chk("u_small_sum", ua.out_sum, 254);
    release_out();
    pkt(2, 20, 30, 0, 0, 0);
    rst_n = 0;
    cur.delete();
    #1;
    chk("mid_rst_in_ready", ua.in_ready, 0);
    chk("mid_rst_valid", ua.out_valid, 0);
    chk("mid_rst_sum", ua.out_sum, 0);
    chk("mid_rst_sat", ua.out_sat, 0);
    chk("mid_rst_ovf", ua.out_ovf, 0);
    chk("mid_rst_count", ua.out_count, 0);
    #2 rst_n = 1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", ua.in_ready, 1);
    pkt(4, 1, 2, 3, 4, 0);
    chk("post_rst_sum", ua.out_sum, 10);
    chk("post_rst_count", ua.out_count, 4);
    release_out();
    rand_ready = 1;
    repeat (200) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        beat(8'($urandom_range(0, 255)), (i == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
